// File: rtl/qr_r_collector_if.sv
// Handshake bundle between the QR_CORDIC row source, the R collector and its downstream consumer.
// Signal names follow the collector's external contract.
interface qr_r_collector_if #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned D_WIDTH    = 4
) ();
  logic                          valid_i;
  logic [DATA_WIDTH*D_WIDTH-1:0] in_r;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport slave (
    input  valid_i, in_r, out_ready,
    output out_data, out_valid, out_last, busy, done, err
  );

  modport master (
    output valid_i, in_r, out_ready,
    input  out_data, out_valid, out_last, busy, done, err
  );
endinterface

// File: rtl/qr_r_collector.sv
// Collects ROWS rows of the R matrix (arriving last row first) and replays them as a
// row-major element stream with valid/ready flow control.
module qr_r_collector #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned D_WIDTH    = 4,
  parameter int unsigned ROWS       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  qr_r_collector_if.slave       bus_io
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam int unsigned CntW = $clog2(ROWS + 1);

  // Packed index D_WIDTH-1 is column 0, matching the MSB-first layout of in_r.
  typedef logic [D_WIDTH-1:0][DATA_WIDTH-1:0] row_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDrain   = 2'd2
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       row_cnt_q;
  logic [RowW-1:0]       rd_row_q;
  logic [ColW-1:0]       rd_col_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  done_q;
  logic                  err_q;
  row_t                  buf_q [ROWS];

  row_t                  in_row;
  logic                  cap_en;
  logic                  last_row;
  logic                  xfer;
  logic [RowW-1:0]       wr_idx;
  logic [RowW-1:0]       nxt_row;
  logic [ColW-1:0]       nxt_col;

  always_comb begin
    in_row   = row_t'(bus_io.in_r);
    cap_en   = bus_io.valid_i && (state_q != StDrain) && !rst;
    last_row = (row_cnt_q == CntW'(ROWS - 1));
    wr_idx   = RowW'(ROWS - 1) - RowW'(row_cnt_q);
    xfer     = out_valid_q && bus_io.out_ready;
    if (rd_col_q == ColW'(D_WIDTH - 1)) begin
      nxt_col = '0;
      nxt_row = rd_row_q + RowW'(1);
    end else begin
      nxt_col = rd_col_q + ColW'(1);
      nxt_row = rd_row_q;
    end
  end

  // Storage only; never read before a full capture, so no reset is needed.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      buf_q[wr_idx] <= in_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      row_cnt_q   <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StCapture: begin
          if (bus_io.valid_i) begin
            if (last_row) begin
              // Last row lands at buffer index 0, so the first element comes straight from in_r.
              state_q     <= StDrain;
              row_cnt_q   <= '0;
              rd_row_q    <= '0;
              rd_col_q    <= '0;
              out_data_q  <= in_row[D_WIDTH-1];
              out_valid_q <= 1'b1;
              out_last_q  <= (ROWS == 1) && (D_WIDTH == 1);
            end else begin
              state_q   <= StCapture;
              row_cnt_q <= row_cnt_q + CntW'(1);
            end
          end
        end
        StDrain: begin
          if (bus_io.valid_i) begin
            err_q <= 1'b1;
          end
          if (xfer) begin
            if (out_last_q) begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              rd_row_q   <= nxt_row;
              rd_col_q   <= nxt_col;
              out_data_q <= buf_q[nxt_row][ColW'(D_WIDTH - 1) - nxt_col];
              out_last_q <= (nxt_row == RowW'(ROWS - 1)) && (nxt_col == ColW'(D_WIDTH - 1));
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          row_cnt_q   <= '0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_last  = out_last_q;
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.done      = done_q;
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_qr_r_collector.sv
// Directed bench for qr_r_collector: a table of matrix scenarios plus hand-written
// reset and abort sequences, checked against an independent element-order model.
module tb_qr_r_collector;

  localparam int unsigned DW   = 20;
  localparam int unsigned DWD  = 4;
  localparam int unsigned ROWS = 8;
  localparam int          NEL  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qr_r_collector_if #(.DATA_WIDTH(DW), .D_WIDTH(DWD)) bus ();

  qr_r_collector #(
    .DATA_WIDTH(DW),
    .D_WIDTH   (DWD),
    .ROWS      (ROWS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string name;
    int    gap;
    bit    stall;
    bit    neg;
    bit    poke;
    bit    exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Element (k-th received row, column c) as generated by the source.
  function automatic logic [DW-1:0] elem(input bit neg, input int k, input int c);
    int v;
    v = k * 4 + c;
    if (neg) return (v % 2 == 0) ? 20'hFFFFF : 20'h80000;
    return DW'(v);
  endfunction

  function automatic logic [DW*DWD-1:0] mk_row(input bit neg, input int k);
    logic [DW*DWD-1:0] r;
    for (int c = 0; c < DWD; c++) r[(DWD-1-c)*DW +: DW] = elem(neg, k, c);
    return r;
  endfunction

  // Output element e comes from buffer row e/4, which holds received row 7 - e/4.
  function automatic logic [DW-1:0] exp_elem(input bit neg, input int e);
    return elem(neg, ROWS - 1 - e / DWD, e % DWD);
  endfunction

  task automatic run_matrix(input vec_t v);
    int               idx;
    int               t;
    bit               prev_stall;
    logic [DW-1:0]    prev;
    bus.out_ready = 1'b0;
    for (int k = 0; k < ROWS; k++) begin
      bus.valid_i = 1'b1;
      bus.in_r    = mk_row(v.neg, k);
      step();
      bus.valid_i = 1'b0;
      bus.in_r    = '0;
      if (k < ROWS - 1) begin
        check({v.name, " busy_cap"}, bus.busy, 1);
        check({v.name, " valid_cap"}, bus.out_valid, 0);
        for (int g = 0; g < v.gap; g++) begin
          step();
          check({v.name, " busy_gap"}, bus.busy, 1);
        end
      end
    end
    check({v.name, " valid_latency"}, bus.out_valid, 1);
    idx = 0;
    t = 0;
    prev_stall = 1'b0;
    prev = '0;
    while (idx < NEL && t < 400) begin
      bus.out_ready = v.stall ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      bus.valid_i   = v.poke && (t == 5);
      if (v.poke && t == 5) bus.in_r = '1;
      check({v.name, " valid_drain"}, bus.out_valid, 1);
      check({v.name, " busy_drain"}, bus.busy, 1);
      if (prev_stall) check({v.name, " hold"}, bus.out_data, prev);
      if (bus.out_valid && bus.out_ready) begin
        check({v.name, " data"}, bus.out_data, exp_elem(v.neg, idx));
        check({v.name, " last"}, bus.out_last, (idx == NEL - 1));
        idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = bus.out_valid;
      end
      prev = bus.out_data;
      t++;
      step();
      bus.valid_i = 1'b0;
      bus.in_r    = '0;
    end
    if (idx < NEL) check({v.name, " timeout"}, idx, NEL);
    check({v.name, " done_pulse"}, bus.done, 1);
    check({v.name, " valid_end"}, bus.out_valid, 0);
    check({v.name, " busy_end"}, bus.busy, 0);
    check({v.name, " last_end"}, bus.out_last, 0);
    bus.out_ready = 1'b0;
    step();
    check({v.name, " done_once"}, bus.done, 0);
    check({v.name, " err"}, bus.err, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{name: "basic", gap: 0, stall: 1'b0, neg: 1'b0, poke: 1'b0, exp_err: 1'b0};
    vecs[1] = '{name: "stall", gap: 0, stall: 1'b1, neg: 1'b0, poke: 1'b0, exp_err: 1'b0};
    vecs[2] = '{name: "gaps",  gap: 2, stall: 1'b0, neg: 1'b0, poke: 1'b0, exp_err: 1'b0};
    vecs[3] = '{name: "neg",   gap: 0, stall: 1'b1, neg: 1'b1, poke: 1'b0, exp_err: 1'b0};
    vecs[4] = '{name: "poke",  gap: 0, stall: 1'b0, neg: 1'b0, poke: 1'b1, exp_err: 1'b1};

    // Reset wins over a simultaneous valid_i.
    rst           = 1'b1;
    bus.valid_i   = 1'b1;
    bus.in_r      = mk_row(1'b0, 3);
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst busy",      bus.busy, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_last",  bus.out_last, 0);
    check("rst done",      bus.done, 0);
    check("rst err",       bus.err, 0);
    check("rst out_data",  bus.out_data, 0);
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    bus.in_r    = '0;
    step();
    check("idle busy", bus.busy, 0);

    foreach (vecs[i]) begin
      run_matrix(vecs[i]);
      step();
    end

    for (int i = 0; i < 3; i++) step();
    check("err sticky", bus.err, 1);

    // Abort a partial capture with reset, then a full matrix must drain cleanly.
    for (int k = 0; k < 5; k++) begin
      bus.valid_i = 1'b1;
      bus.in_r    = mk_row(1'b0, k);
      step();
    end
    bus.valid_i = 1'b0;
    check("abort busy_pre", bus.busy, 1);
    rst         = 1'b1;
    bus.valid_i = 1'b1;
    step();
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    check("abort busy", bus.busy, 0);
    check("abort err",  bus.err, 0);
    check("abort done", bus.done, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort no_done",  bus.done, 0);
      check("abort no_valid", bus.out_valid, 0);
    end
    run_matrix(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/qr_r_collector.md
QR_R_COLLECTOR -- requirements
Module: qr_r_collector

Parameters
REQ-001 DATA_WIDTH, default 20, signed element width in bits.
REQ-002 D_WIDTH, default 4, elements per row (columns).
REQ-003 ROWS, default 8, rows per matrix.

Interface
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 valid_i  input  1  row-valid strobe from QR_CORDIC valid_o.
REQ-007 in_r  input  DATA_WIDTH*D_WIDTH  row from QR_CORDIC out_r; column 0 in MSBs [79:60], column 3 in LSBs [19:0].
REQ-008 out_data  output  DATA_WIDTH  serialized element, signed.
REQ-009 out_valid  output  1  out_data holds a valid element.
REQ-010 out_ready  input  1  downstream accepts the element; transfer = out_valid && out_ready.
REQ-011 out_last  output  1  high with the final element of the matrix.
REQ-012 busy  output  1  high in CAPTURE or DRAIN.
REQ-013 done  output  1  one-cycle pulse after the final transfer.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 States: IDLE, CAPTURE, DRAIN; 2-bit encoding; no other reachable state.
REQ-016 Rows arrive in descending order (row ROWS-1 first); the k-th captured row (k=0..ROWS-1) is stored at buffer index ROWS-1-k.
REQ-017 IDLE: valid_i=1 captures in_r as k=0 and moves to CAPTURE with row count 1.
REQ-018 CAPTURE: each cycle with valid_i=1 stores one row and increments the row count; valid_i=0 holds state (gaps allowed, no timeout).
REQ-019 When the ROWS-th row is stored, move to DRAIN; out_valid rises in the next cycle (latency 1 cycle from the last-row edge).
REQ-020 DRAIN emits elements row-major from buffer index 0, column 0 first; ROWS*D_WIDTH elements total.
REQ-021 out_data/out_last stay stable while out_valid=1 and out_ready=0; they advance only on a transfer.
REQ-022 out_last=1 only with element (ROWS-1, D_WIDTH-1).
REQ-023 A transfer with out_last=1 returns to IDLE, drops out_valid in the next cycle, and pulses done for exactly that cycle.
REQ-024 valid_i=1 in DRAIN is ignored (buffer unchanged) and sets err.
REQ-025 valid_i=1 in the done/IDLE cycle is legal and starts a new capture (back-to-back matrices).
REQ-026 err clears only on rst.
REQ-027 Data passes bit-exact: no rounding, saturation or sign change.
REQ-028 busy = (state != IDLE); out_valid=1 only in DRAIN.

Reset
REQ-029 rst=1 at a rising edge forces IDLE, row/element counters 0, out_valid=0, out_last=0, busy=0, done=0, err=0, out_data=0.
REQ-030 rst has priority over valid_i and out_ready in the same cycle; a partial capture or drain is abandoned with no done pulse.
REQ-031 Buffer contents need no reset; the buffer is unreadable until a full capture completes.

Verification
REQ-032 8 consecutive valid_i rows, the k-th holding {k*4,k*4+1,k*4+2,k*4+3}, out_ready tied 1 -> out_valid one cycle after the 8th row; 32 elements in order 28,29,30,31,24,...,0,1,2,3; out_last on element 3; done one cycle later.
REQ-033 Same input with out_ready toggling 1,0,0,1,... -> identical sequence, no element duplicated or dropped, out_data held stable during stalls.
REQ-034 Rows delivered with 2-cycle gaps between valid_i pulses -> identical output to REQ-032; busy high from the first row through the last transfer.
REQ-035 Negative values: rows with elements -1 (0xFFFFF) and -524288 (0x80000) -> emitted unchanged at 20 bits.
REQ-036 valid_i pulsed during DRAIN -> err=1 and sticky; output sequence unchanged.
REQ-037 rst asserted after 5 captured rows, then a full 8-row matrix -> no done pulse for the aborted matrix; second matrix drains correctly, err=0.
